// File: rtl/fetch_cache_if.sv
// Instruction fetch front end: drives the cache read port, retries on miss, buffers {pc, inst} for decode.
// Optional FETCH_PERF_EN adds issue / miss-cycle performance counters.
module fetch_cache_if #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic [31:0] NEW_PC,
    input  logic        STALL,
    output logic        INST_VALID,
    output logic [31:0] INST_PC,
    output logic [31:0] INST_DATA,
    output logic [31:0] CACHE_HIT_CHECK,
    input  logic        CACHE_HIT_CHECK_RESULT,
    output logic        CACHE_RDEN,
    output logic [31:0] CACHE_RIADDR,
    input  logic [31:0] CACHE_ROADDR,
    input  logic        CACHE_RVALID,
    input  logic [31:0] CACHE_RDATA
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] PERF_ISSUE,
    output logic [31:0] PERF_MISS_CYC
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_ent_t;

    typedef enum logic {S_FETCH, S_MISS} state_t;

    state_t        state;
    logic [31:0]   pc;
    fetch_ent_t    mem [DEPTH];
    fetch_ent_t    hold, head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [AW+1:0] occ;
    logic          inflight, kill;
    logic          space, issue, miss, resp_ok, push, rewind, pop;

    assign occ     = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
    assign space   = occ < (AW+2)'(DEPTH);

    assign CACHE_RDEN      = (space || state == S_MISS) && !FLUSH && !RST;
    assign CACHE_RIADDR    = pc & ~32'h3;
    assign CACHE_HIT_CHECK = CACHE_RIADDR;

    assign issue   = CACHE_RDEN && CACHE_HIT_CHECK_RESULT;
    assign miss    = CACHE_RDEN && !CACHE_HIT_CHECK_RESULT;
    assign resp_ok = inflight && !kill && !FLUSH;
    assign push    = resp_ok && CACHE_RVALID;
    assign rewind  = resp_ok && !CACHE_RVALID;

    assign INST_VALID = count != '0;
    assign pop        = INST_VALID && !STALL && !FLUSH;
    assign head       = INST_VALID ? mem[rptr] : hold;
    assign INST_PC    = head.pc;
    assign INST_DATA  = head.inst;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc       <= RESET_PC;
            state    <= S_FETCH;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else if (FLUSH) begin
            pc       <= NEW_PC & ~32'h3;
            state    <= S_FETCH;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            kill     <= inflight;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            // A rewind makes any word issued this cycle out of order; drop its response too.
            kill     <= rewind && issue;
            if (rewind)
                pc <= CACHE_ROADDR & ~32'h3;
            else if (issue)
                pc <= pc + 32'd4;
            if (miss)
                state <= S_MISS;
            else if (issue)
                state <= S_FETCH;
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST)
            mem[wptr] <= '{pc: CACHE_ROADDR, inst: CACHE_RDATA};
    end

    // Remembers the last presented head so outputs hold steady while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (RST)
            hold <= '0;
        else if (INST_VALID)
            hold <= mem[rptr];
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            PERF_ISSUE    <= '0;
            PERF_MISS_CYC <= '0;
        end else begin
            if (issue)
                PERF_ISSUE <= PERF_ISSUE + 32'd1;
            if (state == S_MISS || miss)
                PERF_MISS_CYC <= PERF_MISS_CYC + 32'd1;
        end
    end
`endif

endmodule
